fd_period_check: RTL
====================

# fd_period_check

Lock/frequency checker that consumes a divided clock, such as the output of the team's divide-by-N stages, as a data signal in the `clk` domain. It measures the period of `div_in` in `clk` cycles and compares it against the expected ratio. After enough consecutive good periods it asserts `lock`. It sits beside the FMDLL dividers as the receiving end of the divided-clock path and flags fast, slow or stalled divider outputs.

## Interface
Parameters:
- `DIV_RATIO`, default 4: expected `div_in` period in `clk` cycles, rise to rise; legal range 2..2^CNT_W-1.
- `TOL`, default 0: allowed absolute deviation of a measured period from `DIV_RATIO`.
- `LOCK_CNT`, default 4: consecutive in-tolerance periods required to lock; legal range 1..255.
- `CNT_W`, default 8: width of the period counter and of `period`.
- `TIMEOUT`, default 255: `clk` cycles without a rise before a stall is declared; must be ≤ 2^CNT_W-1 and > DIV_RATIO+TOL.

Ports:
- `clk` input 1: single clock; all state updates on the posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `div_in` input 1: divided clock under test, sampled as data.
- `lock` output 1: high while in LOCKED.
- `period` output CNT_W: last measured period.
- `period_vld` output 1: one-cycle pulse when `period` is updated.
- `err_fast` output 1: one-cycle pulse when a measured period is < DIV_RATIO-TOL.
- `err_slow` output 1: one-cycle pulse when a measured period is > DIV_RATIO+TOL.
- `stall` output 1: one-cycle pulse on timeout.

## Operation
- Input stage: `div_in` is registered into `s`; `prev` holds the previous `s`; `rise = s & ~prev`.
- `per_cnt` (CNT_W bits):
  - Set to 0 on a rise cycle.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - Measured period is `per_cnt+1`, saturating.
- States:
  - SEARCH (reset state): `per_cnt` is ignored. On rise → TRACK, with `per_cnt`=0 and `match_cnt`=0. No `period_vld` is issued; the first rise only arms the measurement.
  - TRACK: on rise, `period`←measured and `period_vld` pulses.
    - In tolerance: `match_cnt`++. If `match_cnt`+1 == LOCK_CNT → LOCKED.
    - Out of tolerance: `match_cnt`←0, `err_fast` or `err_slow` pulses, stay in TRACK.
  - LOCKED: on rise, `period`/`period_vld` update as in TRACK.
    - In tolerance: stay in LOCKED.
    - Out of tolerance: error pulse, → TRACK with `match_cnt`=0, and `lock` falls on the same edge.
- Timeout: in TRACK or LOCKED, with no rise and `per_cnt`+1 == TIMEOUT:
  - `stall` pulses, state → SEARCH, `lock`←0, `match_cnt`←0.
  - `period` holds its value.
- Simultaneous rise and timeout in the same cycle: the rise wins, and no stall is declared.
- Tolerance compare is done at CNT_W+1 bits, so `DIV_RATIO-TOL` cannot underflow.
- `err_fast`, `err_slow` and `period_vld` never pulse in SEARCH.

## Timing
- Reset state, applied asynchronously: `lock`=0, `period`=0, `period_vld`=0, `err_fast`=0, `err_slow`=0, `stall`=0, state=SEARCH, all counters and sampling flops =0.
- Since `prev` resets to 0, a `div_in` that is high at reset release yields a rise at the first sample. That rise is the arming edge.
- Latency: if `div_in` is first sampled high at edge k, the registered outputs for that rise update at edge k+1. This figure is for the build without the macro in the Configuration section.
- All outputs are registered; pulses are exactly one `clk` cycle wide.
- `lock` rises on the same edge as the `period_vld` of the LOCK_CNT-th consecutive good period.
- Reset asserted mid-operation clears everything immediately, with no wait for `clk`.

## Configuration
- `FD_PERIOD_CHECK_SYNC_EN`: when defined, two extra synchronizer flops are inserted ahead of `s`, so `div_in` may be fully asynchronous to `clk`. Input latency becomes k+3.
- When not defined, `div_in` must be derived from `clk`, for example by a negedge divider, and latency is k+1.
- Measurement results are identical in both builds, offset only by the latency.

## Test plan
- Reset: hold `rst_n`=0 with `div_in` toggling → all outputs 0 and no pulses; release with `div_in`=0 and check that nothing fires until the first rise.
- Steady lock (DIV_RATIO=4, TOL=0, LOCK_CNT=4, `div_in` period 4):
  - Rise 1 arms only.
  - Rises 2–5 give `period_vld` with `period`=4.
  - `lock`=1 on the output edge of rise 5, with no error pulses.
- Slow glitch while locked (one period of 5) → `err_slow` pulse, `period`=5, `lock`→0 on the same edge; `lock` returns after 4 further good periods.
- Fast period while tracking (period 3) → `err_fast` pulse, `period`=3, `match_cnt` restarts. With TOL=1, the same period 3 counts as a match.
- Stall (`div_in` stuck high after lock, TIMEOUT=20) → `stall` pulse 20 cycles after the last rise, `lock`=0, `period` held; the next rise arms only, with no `period_vld`.
- Async reset mid-LOCKED → `lock` drops without a `clk` edge; re-lock requires an arming rise plus 4 good periods. Repeat the whole suite with `FD_PERIOD_CHECK_SYNC_EN` defined and check the 2-cycle latency shift.

Source files
------------

// File: rtl/fd_period_check.sv
// ---------------------------------------------------------------------------
// fd_period_check
//
// Receiving-end checker for a divided clock. div_in is sampled as data in the
// clk domain. The checker measures its rise-to-rise period in clk cycles and
// compares the period against DIV_RATIO +/- TOL. After LOCK_CNT consecutive
// good periods it asserts lock. It also flags fast, slow and stalled inputs.
//
// Optional build macro:
//   FD_PERIOD_CHECK_SYNC_EN - adds a two-flop synchronizer ahead of the
//                             sampling flop, so div_in may be asynchronous.
//                             Output latency grows by two cycles.
//
// Ports:
//   clk        in   single clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   div_in     in   divided clock under test
//   lock       out  high while locked
//   period     out  last measured period (CNT_W bits)
//   period_vld out  one-cycle pulse when period updates
//   err_fast   out  one-cycle pulse, measured period below DIV_RATIO-TOL
//   err_slow   out  one-cycle pulse, measured period above DIV_RATIO+TOL
//   stall      out  one-cycle pulse when no rise is seen for TIMEOUT cycles
// ---------------------------------------------------------------------------
module fd_period_check #(
  parameter int DIV_RATIO = 4,
  parameter int TOL       = 0,
  parameter int LOCK_CNT  = 4,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  output logic             lock,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             err_fast,
  output logic             err_slow,
  output logic             stall
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  // Tolerance bounds live at CNT_W+1 bits; the low bound clamps at zero.
  localparam int LO_INT = (DIV_RATIO > TOL) ? (DIV_RATIO - TOL) : 0;
  localparam int HI_INT = DIV_RATIO + TOL;
  localparam logic [CNT_W:0]   TOL_LO    = LO_INT[CNT_W:0];
  localparam logic [CNT_W:0]   TOL_HI    = HI_INT[CNT_W:0];
  localparam logic [CNT_W:0]   TIMEOUT_C = TIMEOUT[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       MATCH_TGT = LOCK_CNT[7:0];

  state_t           state, state_nxt;
  logic             s, prev;
  logic [CNT_W-1:0] per_cnt;
  logic [7:0]       match_cnt, match_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             vld_nxt, fast_nxt, slow_nxt, stall_nxt;

  logic             rise;
  logic [CNT_W:0]   cnt_plus1;
  logic [CNT_W-1:0] measured;
  logic [CNT_W:0]   measured_ext;
  logic             in_tol;
  logic             timeout_hit;
  logic [7:0]       match_plus1;

`ifdef FD_PERIOD_CHECK_SYNC_EN
  logic sync1, sync2;

  // Two-flop synchronizer in front of the sampling flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s     <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= div_in;
      sync2 <= sync1;
      s     <= sync2;
      prev  <= s;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      s    <= div_in;
      prev <= s;
    end
  end
`endif

  assign rise         = s & ~prev;
  assign cnt_plus1    = {1'b0, per_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign measured     = (per_cnt == CNT_MAX) ? CNT_MAX : cnt_plus1[CNT_W-1:0];
  assign measured_ext = {1'b0, measured};
  assign in_tol       = (measured_ext >= TOL_LO) && (measured_ext <= TOL_HI);
  // A rise in the same cycle takes priority over the timeout.
  assign timeout_hit  = !rise && (cnt_plus1 == TIMEOUT_C);
  assign match_plus1  = match_cnt + 8'd1;

  // Cycles since the last rise. The counter runs in every state; SEARCH
  // simply ignores it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (rise) begin
      per_cnt <= '0;
    end else if (per_cnt != CNT_MAX) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    period_nxt = period;
    vld_nxt    = 1'b0;
    fast_nxt   = 1'b0;
    slow_nxt   = 1'b0;
    stall_nxt  = 1'b0;
    case (state)
      SEARCH: begin
        // The first rise only arms the measurement.
        if (rise) begin
          state_nxt = TRACK;
          match_nxt = 8'd0;
        end
      end
      TRACK, LOCKED: begin
        if (rise) begin
          period_nxt = measured;
          vld_nxt    = 1'b1;
          if (in_tol) begin
            if (state == TRACK) begin
              match_nxt = match_plus1;
              if (match_plus1 == MATCH_TGT) state_nxt = LOCKED;
            end
          end else begin
            match_nxt = 8'd0;
            fast_nxt  = (measured_ext < TOL_LO);
            slow_nxt  = (measured_ext >= TOL_LO);
            state_nxt = TRACK;
          end
        end else if (timeout_hit) begin
          stall_nxt = 1'b1;
          state_nxt = SEARCH;
          match_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        match_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      match_cnt  <= 8'd0;
      lock       <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      err_fast   <= 1'b0;
      err_slow   <= 1'b0;
      stall      <= 1'b0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      lock       <= (state_nxt == LOCKED);
      period     <= period_nxt;
      period_vld <= vld_nxt;
      err_fast   <= fast_nxt;
      err_slow   <= slow_nxt;
      stall      <= stall_nxt;
    end
  end

endmodule
